// File: rtl/vgg_pkg.sv
// vgg_pkg: constants and types shared by the VGG feature-extraction stages.
package vgg_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int L1_CHANNELS = 8;
    localparam int L1_WIDTH    = 112;
    typedef logic [DATA_WIDTH-1:0] fp32_t;
endpackage

// File: rtl/fp32_max.sv
// fp32_max: combinational max of two IEEE-754 singles compared as sign-magnitude.
module fp32_max import vgg_pkg::*; (
    input  fp32_t a_i,
    input  fp32_t b_i,
    output fp32_t y_o
);
    logic a_wins;
    // Raw-bit ordering: NaN and denormals need no special treatment.
    assign a_wins = (a_i[31] != b_i[31]) ? b_i[31] :
                    a_i[31] ? (a_i[30:0] < b_i[30:0]) : (a_i[30:0] > b_i[30:0]);
    assign y_o = a_wins ? a_i : b_i;
endmodule

// File: rtl/pool1_maxpool.sv
// pool1_maxpool: streaming 2x2/stride-2 max-pool over a raster-order WIDTHxWIDTH map.
module pool1_maxpool import vgg_pkg::*; #(
    parameter int DATA_WIDTH = vgg_pkg::DATA_WIDTH,
    parameter int CHANNELS   = vgg_pkg::L1_CHANNELS,
    parameter int WIDTH      = vgg_pkg::L1_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
    input  logic                           valid_in,
    output logic [DATA_WIDTH*CHANNELS-1:0] o_data,
    output logic                           valid_out
);
    localparam int W  = DATA_WIDTH * CHANNELS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

    if (WIDTH % 2 != 0 || WIDTH < 2 || DATA_WIDTH != 32) begin : g_param_check
        $error("pool1_maxpool: WIDTH must be even and DATA_WIDTH must be 32");
    end

    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [W-1:0]  hold_q, hold_d, o_data_q, o_data_d, h, v, rd;
    logic          valid_q, valid_d, col_last, row_last, wr_en;
    logic [AW-1:0] addr;
    logic [W-1:0]  lb_q [WIDTH/2];

    assign addr = AW'(col_q >> 1);
    assign rd   = lb_q[addr];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        fp32_max u_h (
            .a_i(hold_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .b_i(i_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .y_o(h[c*DATA_WIDTH +: DATA_WIDTH])
        );
        fp32_max u_v (
            .a_i(h[c*DATA_WIDTH +: DATA_WIDTH]),
            .b_i(rd[c*DATA_WIDTH +: DATA_WIDTH]),
            .y_o(v[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        col_last = col_q == CW'(WIDTH - 1);
        row_last = row_q == CW'(WIDTH - 1);
        col_d    = valid_in ? (col_last ? '0 : col_q + CW'(1)) : col_q;
        row_d    = (valid_in && col_last) ? (row_last ? '0 : row_q + CW'(1)) : row_q;
        hold_d   = (valid_in && !col_q[0]) ? i_data : hold_q;
        wr_en    = valid_in && col_q[0] && !row_q[0];
        valid_d  = valid_in && col_q[0] && row_q[0];
        o_data_d = valid_d ? v : o_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            hold_q   <= '0;
            o_data_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            hold_q   <= hold_d;
            o_data_q <= o_data_d;
            valid_q  <= valid_d;
        end
    end

    // Every entry is rewritten in an even row before its odd-row read, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) lb_q[addr] <= h;
    end

    assign o_data    = o_data_q;
    assign valid_out = valid_q;
endmodule

// File: tb/tb_pool1_maxpool.sv
// tb_pool1_maxpool: vector table on a 4x4 instance plus random full frames on the 112x112 instance.
module tb_pool1_maxpool;
    localparam int N  = 112;
    localparam int NP = N * N;
    localparam int NO = (N / 2) * (N / 2);

    typedef struct {
        logic [31:0] a, b, c, d, exp, alt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, vin, vout, vin4, vout4;
    logic [255:0] din, dout, din4, dout4;

    pool1_maxpool dut (
        .clk(clk), .rst(rst), .i_data(din), .valid_in(vin), .o_data(dout), .valid_out(vout)
    );
    pool1_maxpool #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .i_data(din4), .valid_in(vin4), .o_data(dout4), .valid_out(vout4)
    );

    int checks = 0;
    int fails  = 0;
    logic [255:0] q[$], q4[$], exp_q[$];
    logic [255:0] frames[2][NP];
    logic pv = 1'b0, pv4 = 1'b0;

    always @(negedge clk) begin
        if (vout) begin
            q.push_back(dout);
            checks++;
            if (pv) begin
                fails++;
                $display("FAIL strobe_112: valid_out high two cycles running at %0t, required single-cycle", $time);
            end
        end
        if (vout4) begin
            q4.push_back(dout4);
            checks++;
            if (pv4) begin
                fails++;
                $display("FAIL strobe_4: valid_out high two cycles running at %0t, required single-cycle", $time);
            end
        end
        pv  <= vout;
        pv4 <= vout4;
    end

    // Reference ordering: map sign-magnitude to a signed integer key.
    function automatic longint fkey(logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    function automatic logic [31:0] fmax(logic [31:0] a, logic [31:0] b);
        return (fkey(a) >= fkey(b)) ? a : b;
    endfunction

    function automatic logic [255:0] pool4(logic [255:0] a, logic [255:0] b, logic [255:0] c, logic [255:0] d);
        logic [255:0] r;
        for (int k = 0; k < 8; k++)
            r[k*32 +: 32] = fmax(fmax(a[k*32 +: 32], b[k*32 +: 32]), fmax(c[k*32 +: 32], d[k*32 +: 32]));
        return r;
    endfunction

    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = $urandom;
            if (w[k*32 +: 32] == 32'h8000_0000) w[k*32 +: 32] = 32'h1;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d outputs required %0d", name, got, want);
        end
    endtask

    task automatic build_exp(input int f);
        exp_q.delete();
        for (int r = 0; r < N / 2; r++)
            for (int c = 0; c < N / 2; c++)
                exp_q.push_back(pool4(frames[f][2*r*N + 2*c], frames[f][2*r*N + 2*c + 1],
                                      frames[f][(2*r+1)*N + 2*c], frames[f][(2*r+1)*N + 2*c + 1]));
    endtask

    task automatic check_frame(input string name, input int base);
        for (int i = 0; i < NO && base + i < q.size(); i++) check(name, q[base + i], exp_q[i]);
    endtask

    task automatic px(input logic [255:0] d);
        @(posedge clk); #2;
        vin = 1'b1;
        din = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            vin  = 1'b0;
            vin4 = 1'b0;
        end
    endtask

    task automatic px4(input logic [31:0] d);
        @(posedge clk); #2;
        vin4 = 1'b1;
        din4 = {8{d}};
    endtask

    task automatic run_frame(input int f, input bit gaps);
        int g;
        for (int i = 0; i < NP; i++) begin
            px(frames[f][i]);
            g = (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            idle(g);
        end
        idle(3);
    endtask

    vec_t        tbl[8];
    logic [31:0] ramp[16];
    logic [31:0] ramp_exp[4];
    logic [31:0] w;

    initial begin
        tbl[0] = '{32'hBF800000, 32'h80000000, 32'h3F000000, 32'hC0000000, 32'h3F000000, 32'h3F000000};
        tbl[1] = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000, 32'hBF800000, 32'hBF800000};
        tbl[2] = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000};
        tbl[3] = '{32'h7FC00000, 32'h3F800000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000};
        tbl[4] = '{32'h00000001, 32'h00000000, 32'h80000005, 32'h00000000, 32'h00000001, 32'h00000001};
        tbl[5] = '{32'h80000003, 32'h80000002, 32'h80000007, 32'hFF800000, 32'h80000002, 32'h80000002};
        tbl[6] = '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFF, 32'h3F800000, 32'h3F800001, 32'h3F800001};
        tbl[7] = '{32'hFFC00000, 32'hFF800000, 32'hFFFFFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF};
        ramp = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
                 32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
        ramp_exp = '{32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000};

        rst = 1'b1; vin = 1'b0; din = '0; vin4 = 1'b0; din4 = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_o_data_112", dout, '0);
        check("reset_valid_112", {255'b0, vout}, '0);
        check("reset_o_data_4", dout4, '0);
        check("reset_valid_4", {255'b0, vout4}, '0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) px4(ramp[i]);
        idle(3);
        check_count("ramp_count", q4.size(), 4);
        for (int i = 0; i < 4 && i < q4.size(); i++) check("ramp_value", q4[i], {8{ramp_exp[i]}});
        q4.delete();

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) begin
                w = (i == 0) ? tbl[t].a : (i == 1) ? tbl[t].b : (i == 4) ? tbl[t].c : (i == 5) ? tbl[t].d : 32'h0;
                px4(w);
            end
            idle(3);
            check_count("table_count", q4.size(), 4);
            if (q4.size() > 0) begin
                checks++;
                if (q4[0] !== {8{tbl[t].exp}} && q4[0] !== {8{tbl[t].alt}}) begin
                    fails++;
                    $display("FAIL table_%0d: got %h required %h", t, q4[0][31:0], tbl[t].exp);
                end
            end
            q4.delete();
        end

        for (int i = 0; i < NP; i++) begin
            frames[0][i] = rnd_word();
            frames[1][i] = rnd_word();
        end
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        check_count("b2b_count", q.size(), 2 * NO);
        build_exp(0);
        check_frame("b2b_frame0", 0);
        build_exp(1);
        check_frame("b2b_frame1", NO);
        q.delete();

        for (int i = 0; i < NP; i++) frames[1][i] = rnd_word();
        for (int i = 0; i < 37 * N + 10; i++) px(frames[1][i]);
        @(posedge clk); #2;
        rst = 1'b1;
        vin = 1'b1;
        din = frames[1][37 * N + 10];
        @(posedge clk); #2;
        check("midreset_o_data", dout, '0);
        check("midreset_valid", {255'b0, vout}, '0);
        rst = 1'b0;
        vin = 1'b0;
        idle(2);
        check_count("partial_count", q.size(), 18 * 56 + 5);
        q.delete();

        run_frame(0, 1'b1);
        check_count("gap_count", q.size(), NO);
        build_exp(0);
        check_frame("gap_frame", 0);
        q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
